// File: rtl/ctl_round.sv
// ctl_round: duck-hunt round controller.
// It sequences each duck through spawn, flight, fall/escape and respawn.
// It also tracks ammo, hits, duck index and round number.
module ctl_round #(
  parameter int unsigned AMMO_PER_DUCK   = 3,
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned HIT_THRESHOLD   = 6,
  parameter int unsigned FLYAWAY_FRAMES  = 300,
  parameter int unsigned RESPAWN_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       start,
  input  logic       pause,
  input  logic       shot_fired,
  input  logic       hit,
  output logic       duck_spawn,
  output logic       duck_active,
  output logic       duck_hit,
  output logic [3:0] ammo,
  output logic [3:0] ducks_hit,
  output logic [3:0] duck_index,
  output logic [3:0] round_no,
  output logic       reset_score,
  output logic       round_won,
  output logic       game_over
);

  localparam int unsigned FTW = $clog2(FLYAWAY_FRAMES + 1);
  localparam int unsigned RTW = $clog2(RESPAWN_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FLYING,
    S_HIT_FALL,
    S_ESCAPED,
    S_ROUND_END,
    S_GAME_OVER
  } state_t;

  state_t         state_q, state_d;
  logic [FTW-1:0] fly_q, fly_d;
  logic [RTW-1:0] resp_q, resp_d;
  logic [3:0]     ammo_q, ammo_d;
  logic [3:0]     hits_q, hits_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     round_q, round_d;
  logic           spawn_q, spawn_d;
  logic           rscore_q, rscore_d;
  logic           won_q, won_d;
  logic           active_q, active_d;
  logic           dhit_q, dhit_d;
  logic           gover_q, gover_d;

  // Next-state, counter and registered-output logic.
  // Pulses are set only on the transition out of their state, so each lasts one cycle.
  // Level outputs follow the next state, so they line up with state_q.
  always_comb begin
    state_d  = state_q;
    fly_d    = fly_q;
    resp_d   = resp_q;
    ammo_d   = ammo_q;
    hits_d   = hits_q;
    idx_d    = idx_q;
    round_d  = round_q;
    spawn_d  = 1'b0;
    rscore_d = 1'b0;
    won_d    = 1'b0;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          state_d  = S_SPAWN;
          rscore_d = 1'b1;
          hits_d   = '0;
          idx_d    = '0;
          round_d  = '0;
        end
      end
      S_SPAWN: begin
        if (!pause) begin
          spawn_d = 1'b1;
          ammo_d  = 4'(AMMO_PER_DUCK);
          fly_d   = '0;
          state_d = S_FLYING;
        end
      end
      S_FLYING: begin
        if (!pause) begin
          if (shot_fired && ammo_q != '0) ammo_d = ammo_q - 4'd1;
          if (new_frame) fly_d = fly_q + FTW'(1);
          // Hit has priority over both the out-of-ammo and the flyaway escapes.
          if (hit) begin
            hits_d  = (hits_q == 4'hF) ? hits_q : hits_q + 4'd1;
            resp_d  = '0;
            state_d = S_HIT_FALL;
          end else if (ammo_d == '0) begin
            resp_d  = '0;
            state_d = S_ESCAPED;
          end else if (new_frame && fly_q == FTW'(FLYAWAY_FRAMES - 1)) begin
            resp_d  = '0;
            state_d = S_ESCAPED;
          end
        end
      end
      S_HIT_FALL, S_ESCAPED: begin
        if (!pause && new_frame) begin
          if (resp_q == RTW'(RESPAWN_FRAMES - 1)) begin
            if (idx_q < 4'(DUCKS_PER_ROUND - 1)) begin
              idx_d   = idx_q + 4'd1;
              state_d = S_SPAWN;
            end else begin
              state_d = S_ROUND_END;
            end
          end else begin
            resp_d = resp_q + RTW'(1);
          end
        end
      end
      S_ROUND_END: begin
        if (!pause) begin
          if (hits_q >= 4'(HIT_THRESHOLD)) begin
            won_d   = 1'b1;
            round_d = round_q + 4'd1;
            hits_d  = '0;
            idx_d   = '0;
            state_d = S_SPAWN;
          end else begin
            state_d = S_GAME_OVER;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d == S_FLYING);
    dhit_d   = (state_d == S_HIT_FALL);
    gover_d  = (state_d == S_GAME_OVER);
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fly_q    <= '0;
      resp_q   <= '0;
      ammo_q   <= '0;
      hits_q   <= '0;
      idx_q    <= '0;
      round_q  <= '0;
      spawn_q  <= 1'b0;
      rscore_q <= 1'b0;
      won_q    <= 1'b0;
      active_q <= 1'b0;
      dhit_q   <= 1'b0;
      gover_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fly_q    <= fly_d;
      resp_q   <= resp_d;
      ammo_q   <= ammo_d;
      hits_q   <= hits_d;
      idx_q    <= idx_d;
      round_q  <= round_d;
      spawn_q  <= spawn_d;
      rscore_q <= rscore_d;
      won_q    <= won_d;
      active_q <= active_d;
      dhit_q   <= dhit_d;
      gover_q  <= gover_d;
    end
  end

  assign duck_spawn  = spawn_q;
  assign duck_active = active_q;
  assign duck_hit    = dhit_q;
  assign ammo        = ammo_q;
  assign ducks_hit   = hits_q;
  assign duck_index  = idx_q;
  assign round_no    = round_q;
  assign reset_score = rscore_q;
  assign round_won   = won_q;
  assign game_over   = gover_q;

endmodule

// File: tb/tb_ctl_round.sv
// Directed bench for ctl_round with default parameters.
// Inputs are driven 1 ns after each rising edge.
// Outputs are checked at the same point, so they reflect the edge just taken.
module tb_ctl_round;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_frame = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       shot_fired = 1'b0;
  logic       hit = 1'b0;
  logic       duck_spawn, duck_active, duck_hit;
  logic [3:0] ammo, ducks_hit, duck_index, round_no;
  logic       reset_score, round_won, game_over;

  int unsigned tests = 0;
  int unsigned fails = 0;

  ctl_round #(
    .AMMO_PER_DUCK  (3),
    .DUCKS_PER_ROUND(10),
    .HIT_THRESHOLD  (6),
    .FLYAWAY_FRAMES (300),
    .RESPAWN_FRAMES (60)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .new_frame  (new_frame),
    .start      (start),
    .pause      (pause),
    .shot_fired (shot_fired),
    .hit        (hit),
    .duck_spawn (duck_spawn),
    .duck_active(duck_active),
    .duck_hit   (duck_hit),
    .ammo       (ammo),
    .ducks_hit  (ducks_hit),
    .duck_index (duck_index),
    .round_no   (round_no),
    .reset_score(reset_score),
    .round_won  (round_won),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Watchdog: the sequence below is bounded, but guard against a stall anyway.
  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Each frame is a one-cycle new_frame pulse followed by one quiet cycle.
  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      tick();
    end
  endtask

  // Finish one duck: either hit at once or spend all three shots; then respawn.
  task automatic do_duck(input bit h);
    if (h) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
    end else begin
      for (int unsigned s = 0; s < 3; s++) begin
        shot_fired = 1'b1;
        tick();
        shot_fired = 1'b0;
        tick();
      end
    end
    frames(60);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ammo", ammo, 0);
    chk("rst_hits", ducks_hit, 0);
    chk("rst_idx", duck_index, 0);
    chk("rst_round", round_no, 0);
    chk("rst_active", duck_active, 0);
    chk("rst_duckhit", duck_hit, 0);
    chk("rst_gover", game_over, 0);
    chk("rst_spawn", duck_spawn, 0);
    chk("rst_rscore", reset_score, 0);
    chk("rst_won", round_won, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_hold_active", duck_active, 0);
    chk("idle_hold_spawn", duck_spawn, 0);

    // Start: reset_score, then duck_spawn one cycle later
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_rscore", reset_score, 1);
    chk("start_no_spawn_yet", duck_spawn, 0);
    tick();
    chk("spawn_pulse", duck_spawn, 1);
    chk("rscore_one_cycle", reset_score, 0);
    chk("spawn_ammo", ammo, 3);
    chk("spawn_active", duck_active, 1);
    tick();
    chk("spawn_one_cycle", duck_spawn, 0);

    // Duck 0: 150 frames, pause 100 frames with shots/hits, then finish the flight timer
    frames(150);
    chk("fly150_active", duck_active, 1);
    pause = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      new_frame = 1'b1; shot_fired = 1'b1; hit = 1'b1;
      tick();
      new_frame = 1'b0; shot_fired = 1'b0; hit = 1'b0;
      tick();
    end
    chk("pause_ammo", ammo, 3);
    chk("pause_active", duck_active, 1);
    chk("pause_duckhit", duck_hit, 0);
    chk("pause_hits", ducks_hit, 0);
    pause = 1'b0;
    frames(149);
    chk("timer_held_active", duck_active, 1);
    frames(1);
    chk("flyaway_active", duck_active, 0);
    chk("flyaway_duckhit", duck_hit, 0);
    frames(59);
    chk("respawn59_idx", duck_index, 0);
    chk("respawn59_spawn", duck_spawn, 0);
    frames(1);
    chk("respawn_idx", duck_index, 1);
    chk("respawn_spawn", duck_spawn, 1);
    chk("respawn_ammo", ammo, 3);

    // Duck 1: hit on the timeout frame wins
    frames(299);
    chk("fly299_active", duck_active, 1);
    new_frame = 1'b1; hit = 1'b1;
    tick();
    new_frame = 1'b0; hit = 1'b0;
    chk("timeout_hit_duckhit", duck_hit, 1);
    chk("timeout_hit_hits", ducks_hit, 1);
    chk("timeout_hit_active", duck_active, 0);
    hit = 1'b1; shot_fired = 1'b1;
    tick();
    hit = 1'b0; shot_fired = 1'b0;
    chk("hit_outside_fly", ducks_hit, 1);
    chk("shot_outside_fly", ammo, 3);
    frames(60);
    chk("duck2_idx", duck_index, 2);

    // Duck 2: three misses, then escape
    shot_fired = 1'b1; tick(); shot_fired = 1'b0;
    chk("ammo_2", ammo, 2);
    shot_fired = 1'b1; tick(); shot_fired = 1'b0;
    chk("ammo_1", ammo, 1);
    shot_fired = 1'b1; tick(); shot_fired = 1'b0;
    chk("ammo_0", ammo, 0);
    chk("ammo_out_escaped", duck_active, 0);
    chk("ammo_out_not_hit", duck_hit, 0);
    frames(60);
    chk("duck3_idx", duck_index, 3);

    // Duck 3: shot and hit together on the last round
    shot_fired = 1'b1; tick(); shot_fired = 1'b0;
    shot_fired = 1'b1; tick(); shot_fired = 1'b0;
    shot_fired = 1'b1; hit = 1'b1;
    tick();
    shot_fired = 1'b0; hit = 1'b0;
    chk("shot_hit_ammo", ammo, 0);
    chk("shot_hit_duckhit", duck_hit, 1);
    chk("shot_hit_hits", ducks_hit, 2);
    chk("shot_hit_active", duck_active, 0);
    frames(59);
    chk("shot_hit_no_escape", duck_hit, 1);
    frames(1);
    chk("duck4_idx", duck_index, 4);

    // Start mid-flight is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ignored_rscore", reset_score, 0);
    chk("start_ignored_hits", ducks_hit, 2);

    // Ducks 4..9: four hits (total 6) and two misses, so round passes
    for (int unsigned d = 4; d < 10; d++) do_duck(d < 8);
    chk("round_won_pulse", round_won, 1);
    chk("round_no_1", round_no, 1);
    chk("round_hits_clr", ducks_hit, 0);
    chk("round_idx_clr", duck_index, 0);
    tick();
    chk("round_won_one_cycle", round_won, 0);
    chk("round1_spawn", duck_spawn, 1);

    // Round 1: only 5 hits -> game over
    for (int unsigned d = 0; d < 10; d++) do_duck(d < 5);
    chk("gover_level", game_over, 1);
    chk("gover_no_won", round_won, 0);
    chk("gover_hits", ducks_hit, 5);
    tick();
    chk("gover_hold", game_over, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_rscore", reset_score, 1);
    chk("restart_round", round_no, 0);
    chk("restart_hits", ducks_hit, 0);
    chk("restart_gover", game_over, 0);
    tick();
    chk("restart_spawn", duck_spawn, 1);
    chk("restart_ammo", ammo, 3);

    // Reset during HIT_FALL clears everything asynchronously
    hit = 1'b1; tick(); hit = 1'b0;
    chk("pre_rst_duckhit", duck_hit, 1);
    rst = 1'b1;
    #2;
    chk("async_rst_duckhit", duck_hit, 0);
    chk("async_rst_ammo", ammo, 0);
    chk("async_rst_hits", ducks_hit, 0);
    chk("async_rst_active", duck_active, 0);
    tick();
    rst = 1'b0;
    frames(61);
    chk("post_rst_idle_active", duck_active, 0);
    chk("post_rst_idle_spawn", duck_spawn, 0);
    chk("post_rst_idle_idx", duck_index, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctl_round.md
CTL_ROUND -- requirements
Module: ctl_round

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- AMMO_PER_DUCK, 3, shots available per duck (1..9).
- DUCKS_PER_ROUND, 10, ducks per round (1..15).
- HIT_THRESHOLD, 6, minimum hits needed to pass a round.
- FLYAWAY_FRAMES, 300, frames a duck flies before escaping.
- RESPAWN_FRAMES, 60, frames between the end of one duck and the spawn of the next.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), with clk and rst listed first:
- clk, in, 1, 65 MHz system clock.
- rst, in, 1, reset; asynchronous, active-high.
- new_frame, in, 1, one-cycle pulse once per VGA frame.
- start, in, 1, one-cycle pulse that starts or restarts the game.
- pause, in, 1, level; high freezes the game.
- shot_fired, in, 1, one-cycle pulse per trigger pull.
- hit, in, 1, one-cycle pulse when a shot lands on the duck.
- duck_spawn, out, 1, one-cycle pulse requesting a new duck.
- duck_active, out, 1, high while the duck is flying and shootable.
- duck_hit, out, 1, high while the hit duck is falling.
- ammo, out, 4, remaining shots, binary.
- ducks_hit, out, 4, hits scored this round.
- duck_index, out, 4, index of the current duck (0-based).
- round_no, out, 4, current round; wraps 15 to 0.
- reset_score, out, 1, one-cycle pulse that clears the score.
- round_won, out, 1, one-cycle pulse when a round is passed.
- game_over, out, 1, high in GAME_OVER.

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, SPAWN, FLYING, HIT_FALL, ESCAPED, ROUND_END and GAME_OVER; all outputs SHALL be registered.
REQ-004 In IDLE, a start pulse SHALL go to SPAWN, pulse reset_score for one cycle, and clear ducks_hit, duck_index and round_no.
REQ-005 SPAWN SHALL last exactly one cycle: duck_spawn=1, ammo:=AMMO_PER_DUCK, flight timer cleared; the next state SHALL be FLYING.
REQ-006 In FLYING, duck_active SHALL be 1, and the flight timer SHALL increment on each new_frame while pause=0.
REQ-007 In FLYING, shot_fired with ammo>0 SHALL decrement ammo by 1; with ammo=0 it SHALL be ignored (ammo saturates at 0).
REQ-008 In FLYING, hit SHALL go to HIT_FALL and increment ducks_hit (saturating at 15).
REQ-009 When shot_fired and hit arrive in the same cycle, the block SHALL decrement ammo once and go to HIT_FALL.
REQ-010 In FLYING, ammo reaching 0 without a hit in that cycle SHALL go to ESCAPED on the next cycle.
REQ-011 In FLYING, the flight timer reaching FLYAWAY_FRAMES SHALL go to ESCAPED; if hit arrives in the same cycle, hit SHALL win.
REQ-012 In HIT_FALL (duck_hit=1) and in ESCAPED, a respawn timer SHALL count new_frame pulses (while pause=0), and after RESPAWN_FRAMES frames:
- if duck_index < DUCKS_PER_ROUND-1, the block SHALL increment duck_index and go to SPAWN;
- otherwise it SHALL go to ROUND_END.
REQ-013 ROUND_END SHALL last one cycle:
- if ducks_hit >= HIT_THRESHOLD: pulse round_won, increment round_no, clear ducks_hit and duck_index, and go to SPAWN;
- otherwise go to GAME_OVER.
REQ-014 In GAME_OVER, game_over SHALL be 1, and a start pulse SHALL behave exactly as start in IDLE.
REQ-015 While pause=1, the block SHALL ignore shot_fired, hit and new_frame and hold its state and all counters; start SHALL remain effective.
REQ-016 A start pulse in any state other than IDLE or GAME_OVER SHALL be ignored.
REQ-017 hit or shot_fired outside FLYING SHALL have no effect.
REQ-018 duck_spawn, reset_score and round_won SHALL each be high for exactly one clk cycle.

Reset
REQ-019 On rst=1, the block SHALL asynchronously enter IDLE, with ammo=0, ducks_hit=0, duck_index=0, round_no=0 and all pulse and level outputs 0.
REQ-020 rst asserted mid-flight SHALL abort the duck with no pulse emitted.
REQ-021 After rst deasserts, the block SHALL remain in IDLE until a start pulse.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then start -> reset_score and duck_spawn pulses one cycle apart; ammo=3; duck_active=1.
- Three shot_fired pulses with no hit -> ammo 3,2,1,0, then ESCAPED; after 60 frames duck_index=1 and duck_spawn pulses.
- shot_fired and hit in the same cycle with ammo=1 -> ammo=0, duck_hit=1, ducks_hit+1, no ESCAPED.
- No shots for 300 frames -> ESCAPED; a hit arriving on the timeout cycle -> HIT_FALL instead.
- 10 ducks with 6 hits -> round_won pulse, round_no=1, ducks_hit=0; with 5 hits -> game_over=1, and start restarts the game with round_no=0.
- pause=1 for 100 frames in FLYING -> timer, ammo and state unchanged, shots ignored; rst during HIT_FALL -> IDLE immediately with outputs 0.
